// File: rtl/tt_proj_sel_ctrl.sv
// tt_proj_sel_ctrl: sequences the one-hot project enable and shared project reset through reset, gap and release phases.
module tt_proj_sel_ctrl #(
    parameter int N_PROJ  = 24,
    parameter int ADDR_W  = 5,
    parameter int RST_CYC = 4,
    parameter int GAP_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel_valid,
    input  logic [ADDR_W-1:0] i_sel_addr,
    output logic              o_sel_ready,
    output logic [N_PROJ-1:0] o_ena,
    output logic              o_proj_rst_n,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic              o_cur_valid,
    output logic              o_done
);
    typedef enum logic [2:0] {S_IDLE, S_OLD_RST, S_GAP, S_NEW_RST, S_ACTIVE} state_t;
    localparam logic [7:0] RST_LD = 8'(RST_CYC - 1);
    localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);
    localparam logic [ADDR_W:0] N_LIM = (ADDR_W+1)'(N_PROJ);

    state_t              r_state, w_nxt_state;
    logic [7:0]          r_cnt, w_nxt_cnt;
    logic [ADDR_W-1:0]   r_target, w_nxt_target;
    logic [N_PROJ-1:0]   r_ena, w_nxt_ena;
    logic                r_prst_n, w_nxt_prst_n;
    logic [ADDR_W-1:0]   r_cur_addr, w_nxt_cur_addr;
    logic                r_cur_valid, w_nxt_cur_valid;
    logic                r_done, w_nxt_done;
    logic                w_accept, w_sel_ok, w_tgt_ok, w_cnt_zero;

    assign o_sel_ready  = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    assign o_ena        = r_ena;
    assign o_proj_rst_n = r_prst_n;
    assign o_cur_addr   = r_cur_addr;
    assign o_cur_valid  = r_cur_valid;
    assign o_done       = r_done;

    always_comb begin
        w_accept        = i_sel_valid && o_sel_ready;
        w_sel_ok        = {1'b0, i_sel_addr} < N_LIM;
        w_tgt_ok        = {1'b0, r_target} < N_LIM;
        w_cnt_zero      = r_cnt == 8'd0;
        w_nxt_state     = r_state;
        w_nxt_cnt       = w_cnt_zero ? r_cnt : r_cnt - 8'd1;
        w_nxt_target    = r_target;
        w_nxt_ena       = r_ena;
        w_nxt_prst_n    = r_prst_n;
        w_nxt_cur_addr  = r_cur_addr;
        w_nxt_cur_valid = r_cur_valid;
        w_nxt_done      = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_nxt_target = i_sel_addr;
                if (w_sel_ok) begin
                    w_nxt_state     = S_NEW_RST;
                    w_nxt_cnt       = RST_LD;
                    w_nxt_ena       = N_PROJ'(1) << i_sel_addr;
                    w_nxt_prst_n    = 1'b0;
                    w_nxt_cur_addr  = i_sel_addr;
                    w_nxt_cur_valid = 1'b1;
                end else begin
                    w_nxt_done = 1'b1;
                end
            end
            S_OLD_RST: if (w_cnt_zero) begin
                w_nxt_state     = S_GAP;
                w_nxt_cnt       = GAP_LD;
                w_nxt_ena       = '0;
                w_nxt_cur_valid = 1'b0;
            end
            // the gap always separates old and new enables, even for the same address
            S_GAP: if (w_cnt_zero) begin
                if (w_tgt_ok) begin
                    w_nxt_state     = S_NEW_RST;
                    w_nxt_cnt       = RST_LD;
                    w_nxt_ena       = N_PROJ'(1) << r_target;
                    w_nxt_cur_addr  = r_target;
                    w_nxt_cur_valid = 1'b1;
                end else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_done  = 1'b1;
                end
            end
            S_NEW_RST: if (w_cnt_zero) begin
                w_nxt_state  = S_ACTIVE;
                w_nxt_prst_n = 1'b1;
                w_nxt_done   = 1'b1;
            end
            S_ACTIVE: if (w_accept) begin
                w_nxt_state  = S_OLD_RST;
                w_nxt_cnt    = RST_LD;
                w_nxt_target = i_sel_addr;
                w_nxt_prst_n = 1'b0;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_target    <= '0;
            r_ena       <= '0;
            r_prst_n    <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_target    <= w_nxt_target;
            r_ena       <= w_nxt_ena;
            r_prst_n    <= w_nxt_prst_n;
            r_cur_addr  <= w_nxt_cur_addr;
            r_cur_valid <= w_nxt_cur_valid;
            r_done      <= w_nxt_done;
        end
    end
endmodule

// File: tb/tb_tt_proj_sel_ctrl.sv
// tb_tt_proj_sel_ctrl: table-driven select sequences plus a random run checking enable invariants.
module tb_tt_proj_sel_ctrl;
    logic        clk = 1'b0;
    logic        rst, vld;
    logic [4:0]  addr;
    logic        rdy, prst_n, cur_valid, done;
    logic [23:0] ena;
    logic [4:0]  cur_addr;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  addr;
        logic        rdy;
        logic [23:0] ena;
        logic        prst;
        logic [4:0]  ca;
        logic        cv;
        logic        done;
    } vec_t;
    vec_t tv[$];

    tt_proj_sel_ctrl #(.N_PROJ(24), .ADDR_W(5), .RST_CYC(4), .GAP_CYC(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_sel_valid(vld), .i_sel_addr(addr),
        .o_sel_ready(rdy), .o_ena(ena), .o_proj_rst_n(prst_n),
        .o_cur_addr(cur_addr), .o_cur_valid(cur_valid), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [4:0] a, input logic ry,
                       input logic [23:0] e, input logic p, input logic [4:0] ca,
                       input logic cv, input logic d, input int n = 1);
        for (int i = 0; i < n; i++) tv.push_back('{r, v, a, ry, e, p, ca, cv, d});
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    initial begin
        logic [23:0] pe;
        logic        pp, r;
        rst = 1'b1; vld = 1'b0; addr = '0;
        // reset
        add(1, 0, 0, 1, 24'h0, 0, 0, 0, 0, 2);
        // IDLE select 5
        add(0, 1, 5, 0, 24'h000020, 0, 5, 1, 0);
        add(0, 0, 0, 0, 24'h000020, 0, 5, 1, 0, 3);
        add(0, 0, 0, 1, 24'h000020, 1, 5, 1, 1);
        add(0, 0, 0, 1, 24'h000020, 1, 5, 1, 0);
        // ACTIVE(5) select 17, valid held with changing addr
        add(0, 1, 17, 0, 24'h000020, 0, 5, 1, 0);
        add(0, 1, 3, 0, 24'h000020, 0, 5, 1, 0);
        add(0, 1, 9, 0, 24'h000020, 0, 5, 1, 0);
        add(0, 1, 31, 0, 24'h000020, 0, 5, 1, 0);
        add(0, 1, 2, 0, 24'h0, 0, 5, 0, 0, 2);
        add(0, 1, 7, 0, 24'h020000, 0, 17, 1, 0, 4);
        add(0, 0, 0, 1, 24'h020000, 1, 17, 1, 1);
        add(0, 0, 0, 1, 24'h020000, 1, 17, 1, 0);
        // ACTIVE(17) select 31 -> IDLE
        add(0, 1, 31, 0, 24'h020000, 0, 17, 1, 0);
        add(0, 0, 0, 0, 24'h020000, 0, 17, 1, 0, 3);
        add(0, 0, 0, 0, 24'h0, 0, 17, 0, 0, 2);
        add(0, 0, 0, 1, 24'h0, 0, 17, 0, 1);
        add(0, 0, 0, 1, 24'h0, 0, 17, 0, 0);
        // IDLE select 24 (first invalid address)
        add(0, 1, 24, 1, 24'h0, 0, 17, 0, 1);
        add(0, 0, 0, 1, 24'h0, 0, 17, 0, 0);
        // reset during NEW_RST
        add(0, 1, 5, 0, 24'h000020, 0, 5, 1, 0);
        add(1, 0, 0, 1, 24'h0, 0, 0, 0, 0);
        // reset during GAP
        add(0, 1, 2, 0, 24'h000004, 0, 2, 1, 0);
        add(0, 0, 0, 0, 24'h000004, 0, 2, 1, 0, 3);
        add(0, 0, 0, 1, 24'h000004, 1, 2, 1, 1);
        add(0, 1, 9, 0, 24'h000004, 0, 2, 1, 0);
        add(0, 0, 0, 0, 24'h000004, 0, 2, 1, 0, 3);
        add(0, 0, 0, 0, 24'h0, 0, 2, 0, 0);
        add(1, 0, 0, 1, 24'h0, 0, 0, 0, 0);
        // boundary address 23, then re-select 23 (full cycle through gap)
        add(0, 1, 23, 0, 24'h800000, 0, 23, 1, 0);
        add(0, 0, 0, 0, 24'h800000, 0, 23, 1, 0, 3);
        add(0, 0, 0, 1, 24'h800000, 1, 23, 1, 1);
        add(0, 1, 23, 0, 24'h800000, 0, 23, 1, 0);
        add(0, 0, 0, 0, 24'h800000, 0, 23, 1, 0, 3);
        add(0, 0, 0, 0, 24'h0, 0, 23, 0, 0, 2);
        add(0, 0, 0, 0, 24'h800000, 0, 23, 1, 0, 4);
        add(0, 0, 0, 1, 24'h800000, 1, 23, 1, 1);

        foreach (tv[k]) begin
            rst = tv[k].rst; vld = tv[k].vld; addr = tv[k].addr;
            @(posedge clk); #1;
            chk("sel_ready", k, 32'(rdy), 32'(tv[k].rdy));
            chk("ena", k, 32'(ena), 32'(tv[k].ena));
            chk("proj_rst_n", k, 32'(prst_n), 32'(tv[k].prst));
            chk("cur_addr", k, 32'(cur_addr), 32'(tv[k].ca));
            chk("cur_valid", k, 32'(cur_valid), 32'(tv[k].cv));
            chk("done", k, 32'(done), 32'(tv[k].done));
        end

        pe = ena; pp = prst_n;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99) == 0;
            rst = r; vld = $urandom_range(0, 3) == 0; addr = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
            chk("popcount_le1", i, 32'($countones(ena) <= 1), 32'd1);
            if (!r && pp) chk("ena_stable_while_running", i, 32'(ena), 32'(pe));
            if (!r && pe != 0 && ena != 0) chk("no_direct_switch", i, 32'(ena), 32'(pe));
            pe = ena; pp = prst_n;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
